// File: rtl/imm_gen_stage_if.sv
// Handshake bundle for imm_gen_stage: instruction/tag in, decoded immediate/flags/tag out.
interface imm_gen_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: combinational RV32I/RV64I immediate decode, registered on
// acceptance, with an output register plus one skid entry for full throughput under backpressure.
module imm_gen_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned LS_SHIFT = 2,
  parameter int unsigned TAG_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  imm_gen_stage_if.slave   bus
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [2:0] FmtNone  = 3'd0;
  localparam logic [2:0] FmtI     = 3'd1;
  localparam logic [2:0] FmtS     = 3'd2;
  localparam logic [2:0] FmtB     = 3'd3;
  localparam logic [2:0] FmtU     = 3'd4;
  localparam logic [2:0] FmtJ     = 3'd5;
  localparam logic [2:0] FmtShamt = 3'd6;
  localparam logic [2:0] FmtZimm  = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [31:0]     i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Every format pre-sign-extended to 32 bits; sext() widens to XLEN.
  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'b0};
  assign j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec_imm = '0;
    dec_fmt = FmtNone;
    dec_ill = 1'b0;
    case (opcode)
      OpLui, OpAuipc: begin dec_imm = sext(u_imm); dec_fmt = FmtU; end
      OpJal:          begin dec_imm = sext(j_imm); dec_fmt = FmtJ; end
      OpJalr:         begin dec_imm = sext(i_imm); dec_fmt = FmtI; end
      OpBranch:       begin dec_imm = sext(b_imm); dec_fmt = FmtB; end
      OpLoad:         begin dec_imm = sext(i_imm) << LS_SHIFT; dec_fmt = FmtI; end
      OpStore:        begin dec_imm = sext(s_imm) << LS_SHIFT; dec_fmt = FmtS; end
      OpOpImm: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_fmt = FmtShamt;
          if (XLEN == 32) begin
            dec_imm = XLEN'(instr[24:20]);
            dec_ill = instr[25];
          end else begin
            dec_imm = XLEN'(instr[25:20]);
          end
        end else begin
          dec_imm = sext(i_imm);
          dec_fmt = FmtI;
        end
      end
      OpSystem: begin
        if (funct3[2]) begin
          dec_imm = XLEN'(instr[19:15]);
          dec_fmt = FmtZimm;
        end
      end
      default: ;
    endcase
  end

  entry_t out_q, out_d, skid_q, skid_d, new_e;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic   accept, drain;

  assign new_e  = '{imm: dec_imm, fmt: dec_fmt, ill: dec_ill, tag: bus.in_tag};
  assign accept = bus.in_valid && !skid_valid_q;
  assign drain  = out_valid_q && bus.out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Input is blocked while the skid is occupied; only a drain can make progress.
      if (drain) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || drain) begin
        out_d       = new_e;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = new_e;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.ill;
  assign bus.out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: directed cases plus random traffic on XLEN=32 and XLEN=64 instances,
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_imm_gen_stage;

  localparam int LS = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(32)) b64 ();

  imm_gen_stage #(.XLEN(32), .LS_SHIFT(LS), .TAG_W(32)) dut32 (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (b32)
  );

  imm_gen_stage #(.XLEN(64), .LS_SHIFT(LS), .TAG_W(32)) dut64 (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (b64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Signed contribution of a sign bit sitting at bit position pos.
  function automatic longint sx(input logic s, input int pos);
    return s ? -(longint'(1) << pos) : longint'(0);
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input int xlen, input logic [31:0] tag);
    exp_t   e;
    longint v;
    logic [2:0] f3;
    v     = 0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    e.tag = tag;
    f3    = ins[14:12];
    case (ins[6:0])
      7'b0110111, 7'b0010111: begin
        v = sx(ins[31], 31) + (longint'(ins[30:12]) << 12); e.fmt = 3'd4;
      end
      7'b1101111: begin
        v = sx(ins[31], 20) + (longint'(ins[19:12]) << 12) + (longint'(ins[20]) << 11)
            + (longint'(ins[30:21]) << 1);
        e.fmt = 3'd5;
      end
      7'b1100111: begin v = sx(ins[31], 11) + longint'(ins[30:20]); e.fmt = 3'd1; end
      7'b1100011: begin
        v = sx(ins[31], 12) + (longint'(ins[7]) << 11) + (longint'(ins[30:25]) << 5)
            + (longint'(ins[11:8]) << 1);
        e.fmt = 3'd3;
      end
      7'b0000011: begin v = (sx(ins[31], 11) + longint'(ins[30:20])) << LS; e.fmt = 3'd1; end
      7'b0100011: begin
        v = (sx(ins[31], 11) + (longint'(ins[30:25]) << 5) + longint'(ins[11:7])) << LS;
        e.fmt = 3'd2;
      end
      7'b0010011: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.fmt = 3'd6;
          if (xlen == 32) begin v = longint'(ins[24:20]); e.ill = ins[25]; end
          else v = longint'(ins[25:20]);
        end else begin
          v = sx(ins[31], 11) + longint'(ins[30:20]); e.fmt = 3'd1;
        end
      end
      7'b1110011: if (f3[2]) begin v = longint'(ins[19:15]); e.fmt = 3'd7; end
      default: ;
    endcase
    e.imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
    return e;
  endfunction

  // Drive one cycle on the 32-bit instance; transfers are judged mid-cycle, before the edge.
  task automatic step32(input logic v, input logic [31:0] ins, input logic [31:0] tag,
                        input logic rdy);
    exp_t e;
    b32.in_valid = v; b32.in_instr = ins; b32.in_tag = tag; b32.out_ready = rdy;
    @(negedge clk);
    if (b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) chk("spurious_out32", 64'(b32.out_tag), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = q32.pop_front();
        chk("imm32", 64'(b32.out_imm), e.imm);
        chk("fmt32", 64'(b32.out_fmt), 64'(e.fmt));
        chk("ill32", 64'(b32.out_illegal), 64'(e.ill));
        chk("tag32", 64'(b32.out_tag), 64'(e.tag));
      end
    end
    if (flush) q32.delete();
    else if (b32.in_valid && b32.in_ready) q32.push_back(model(ins, 32, tag));
    @(posedge clk); #1;
  endtask

  task automatic step64(input logic v, input logic [31:0] ins, input logic [31:0] tag,
                        input logic rdy);
    exp_t e;
    b64.in_valid = v; b64.in_instr = ins; b64.in_tag = tag; b64.out_ready = rdy;
    @(negedge clk);
    if (b64.out_valid && b64.out_ready) begin
      if (q64.size() == 0) chk("spurious_out64", 64'(b64.out_tag), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = q64.pop_front();
        chk("imm64", b64.out_imm, e.imm);
        chk("fmt64", 64'(b64.out_fmt), 64'(e.fmt));
        chk("ill64", 64'(b64.out_illegal), 64'(e.ill));
        chk("tag64", 64'(b64.out_tag), 64'(e.tag));
      end
    end
    if (flush) q64.delete();
    else if (b64.in_valid && b64.in_ready) q64.push_back(model(ins, 64, tag));
    @(posedge clk); #1;
  endtask

  // Single accepted instruction with literal expectations, visible one cycle later.
  task automatic dir32(input logic [31:0] ins, input logic [31:0] tag, input logic [31:0] imm,
                       input logic [2:0] fmt, input logic ill);
    step32(1'b1, ins, tag, 1'b1);
    chk("dir32_valid", 64'(b32.out_valid), 64'd1);
    chk("dir32_imm", 64'(b32.out_imm), 64'(imm));
    chk("dir32_fmt", 64'(b32.out_fmt), 64'(fmt));
    chk("dir32_ill", 64'(b32.out_illegal), 64'(ill));
  endtask

  task automatic dir64(input logic [31:0] ins, input logic [31:0] tag, input logic [63:0] imm,
                       input logic [2:0] fmt, input logic ill);
    step64(1'b1, ins, tag, 1'b1);
    chk("dir64_valid", 64'(b64.out_valid), 64'd1);
    chk("dir64_imm", b64.out_imm, imm);
    chk("dir64_fmt", 64'(b64.out_fmt), 64'(fmt));
    chk("dir64_ill", 64'(b64.out_illegal), 64'(ill));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] r;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b1110011, 7'b0110011};
    r = $urandom();
    if ($urandom_range(0, 9) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 9)]};
  endfunction

  localparam logic [31:0] Nop = 32'h0000_0013;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_tag = '0; b64.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
    chk("rst_imm", 64'(b32.out_imm), 64'd0);
    chk("rst_fmt", 64'(b32.out_fmt), 64'd0);
    chk("rst_ill", 64'(b32.out_illegal), 64'd0);
    chk("rst_tag", 64'(b32.out_tag), 64'd0);
    chk("rst_imm64", b64.out_imm, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed decode, back to back.
    dir32(32'hFFF0_0093, 1, 32'hFFFF_FFFF, 3'd1, 1'b0);
    dir32(32'h4030_D093, 2, 32'h0000_0003, 3'd6, 1'b0);
    dir32(32'h0080_2083, 3, 32'h0000_0020, 3'd1, 1'b0);
    dir32(32'hFE00_0EE3, 4, 32'hFFFF_FFFC, 3'd3, 1'b0);
    dir32(32'h1234_52B7, 5, 32'h1234_5000, 3'd4, 1'b0);
    dir32(32'h0220_D093, 6, 32'h0000_0002, 3'd6, 1'b1);
    step32(1'b0, Nop, 0, 1'b1);
    step32(1'b0, Nop, 0, 1'b1);

    // Backpressure: 1 to output, 2 to skid, 3 stalled.
    step32(1'b1, Nop, 1, 1'b0);
    step32(1'b1, Nop, 2, 1'b0);
    chk("bp_in_ready_full", 64'(b32.in_ready), 64'd0);
    step32(1'b1, Nop, 3, 1'b0);
    chk("bp_in_ready_held", 64'(b32.in_ready), 64'd0);
    chk("bp_hold_tag", 64'(b32.out_tag), 64'd1);
    step32(1'b1, Nop, 3, 1'b1);
    chk("bp_tag2", 64'(b32.out_tag), 64'd2);
    chk("bp_in_ready_back", 64'(b32.in_ready), 64'd1);
    step32(1'b1, Nop, 3, 1'b1);
    chk("bp_tag3", 64'(b32.out_tag), 64'd3);
    step32(1'b0, Nop, 0, 1'b1);
    chk("bp_drained", 64'(b32.out_valid), 64'd0);

    // Flush with both entries full, then with one entry and an acceptable input.
    step32(1'b1, Nop, 10, 1'b0);
    step32(1'b1, Nop, 11, 1'b0);
    flush = 1'b1;
    step32(1'b1, Nop, 12, 1'b0);
    flush = 1'b0;
    chk("flush_out_valid", 64'(b32.out_valid), 64'd0);
    chk("flush_in_ready", 64'(b32.in_ready), 64'd1);
    step32(1'b1, Nop, 13, 1'b0);
    flush = 1'b1;
    step32(1'b1, Nop, 14, 1'b1);
    flush = 1'b0;
    chk("flush2_out_valid", 64'(b32.out_valid), 64'd0);
    for (int i = 0; i < 3; i++) step32(1'b0, Nop, 0, 1'b1);

    // Asynchronous reset between edges.
    step32(1'b1, Nop, 20, 1'b0);
    step32(1'b1, Nop, 21, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("arst_in_ready", 64'(b32.in_ready), 64'd1);
    q32.delete();
    b32.in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_no_output", 64'(b32.out_valid), 64'd0);
    step32(1'b1, Nop, 30, 1'b1);
    chk("arst_lat_valid", 64'(b32.out_valid), 64'd1);
    chk("arst_lat_tag", 64'(b32.out_tag), 64'd30);
    step32(1'b0, Nop, 0, 1'b1);

    // Random traffic, XLEN=32.
    for (int i = 0; i < 400; i++)
      step32($urandom_range(0, 3) != 0, rand_instr(), 32'(100 + i), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 3; i++) step32(1'b0, Nop, 0, 1'b1);
    chk("q32_empty", 64'(q32.size()), 64'd0);

    // XLEN=64 directed and random.
    dir64(32'h0220_D093, 40, 64'h0000_0000_0000_0022, 3'd6, 1'b0);
    dir64(32'hFFF0_0093, 41, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    dir64(32'h8000_0037, 42, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    for (int i = 0; i < 400; i++)
      step64($urandom_range(0, 3) != 0, rand_instr(), 32'(1000 + i), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 3; i++) step64(1'b0, Nop, 0, 1'b1);
    chk("q64_empty", 64'(q64.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
